cp0_exc_controller: RTL and testbench
=====================================

Name: cp0_exc_controller

Overview:
Owns the CP0 architectural registers (Count, Compare, Status, Cause, EPC) and sequences pipeline redirection when the WB-stage exception handler raises exc or ERET.
- Commits the handler's computed field updates, then drives flush and redirect handshakes to the fetch/pipeline control.
- Arbitrates CP0 writes between MTC0 in WB and exception commits.
- Generates the Count/Compare timer interrupt.

Parameters:
FLUSH_CYCLES, 1, cycles flush is held before redirect (1..7)
COUNT_DIV, 2, clk cycles per Count increment (>=1)
STATUS_RST, 32'h0040_0004, Status reset value (BEV=1, ERL=1, IE=0)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
exc_req  in  1  exception/ERET commit request from handler (WB)
exc_addr  in  32  redirect target from handler
new_exl  in  1  handler's next Status.EXL
new_exccode  in  5  handler's next Cause.ExcCode
new_bd  in  1  handler's next Cause.BD
new_hip  in  6  handler's next Cause[15:10]
new_epc  in  32  handler's next EPC
mtc0_we  in  1  MTC0 write enable (WB)
mtc0_addr  in  5  CP0 register number
mtc0_data  in  32  write data
mfc0_addr  in  5  read register number
mfc0_data  out  32  combinational read data
status_out  out  32  Status to handler
cause_out  out  32  Cause to handler
epc_out  out  32  EPC to handler
timer_int  out  1  timer pending (Cause[15])
flush  out  1  kill all IF..MEM instructions
stall  out  1  freeze PC/pipeline regs
redirect_valid  out  1  one-cycle PC load strobe
redirect_pc  out  32  PC load value

Behaviour:
- Reset (async, rst_n=0): Status=STATUS_RST, Cause=0, EPC=0, Count=0, Compare=32'hFFFF_FFFF, div counter=0, state=IDLE, redirect_pc=0. flush, stall and redirect_valid all 0.
- FSM states: IDLE, FLUSH, REDIRECT.
- IDLE + exc_req=1 at the edge:
  - Write Status[1]=new_exl, Cause[6:2]=new_exccode, Cause[31]=new_bd, Cause[15:10]=new_hip, EPC=new_epc.
  - Latch redirect_pc=exc_addr; load flush counter with FLUSH_CYCLES-1; go to FLUSH.
- FLUSH: flush=1, stall=1. Counter decrements each cycle; at 0 go to REDIRECT.
- REDIRECT: redirect_valid=1, stall=1, flush=0 for exactly one cycle, then IDLE.
- Total latency from commit edge to PC load is FLUSH_CYCLES+1 cycles.
- exc_req while not IDLE is ignored; the pipeline is being flushed.
- MTC0 (IDLE only, exc_req=0) write masks:
  - 9 Count: full write.
  - 11 Compare: full write; also clears Cause[15].
  - 12 Status: full write.
  - 13 Cause: bits [23] and [9:8] only.
  - 14 EPC: full write.
  - Other addresses: no effect.
- MTC0 and exc_req in the same cycle: exception wins; the MTC0 write is dropped.
- MTC0 while not IDLE: dropped.
- Count increments by 1 every COUNT_DIV cycles and wraps 32'hFFFF_FFFF -> 0. An MTC0 Count write takes priority over the increment that cycle and resets the divider.
- Timer: when Count==Compare after update and Compare was not written that cycle, set Cause[15]. Cause[15] stays set until a Compare write. An exception commit ORs the timer bit into new_hip[5], so the timer bit is never lost.
- mfc0_data: combinational read of 9/11/12/13/14; 0 for any other address. An MFC0 in the same cycle as a write returns the old value.
- status_out, cause_out, epc_out present the current register values. timer_int = Cause[15].
- rst_n asserted mid-sequence: abort immediately to IDLE with all outputs at reset values; no redirect is issued.

Decomposition:
Shared package cp0_defs holds:
- CP0 register numbers (9, 11, 12, 13, 14).
- Status/Cause bit positions: EXL=1, ERL=2, IE=0, BEV=22, IV=23, BD=31, IP=15:8, ExcCode=6:2.
- FSM state encodings.
- STATUS_RST default.

One sub-module is natural: cp0_timer, holding Count, Compare, the divider and the pending flag.

Test Plan:
- Reset release -> Status=0040_0004, Compare=FFFF_FFFF, flush=0; mfc0_addr=12 returns 0040_0004.
- exc_req=1 with exc_addr=8000_0180, new_epc=0000_1004, new_exccode=0C, FLUSH_CYCLES=1 -> next cycle flush=1; cycle after: redirect_valid=1 and redirect_pc=8000_0180; EPC=0000_1004, Cause[6:2]=0C.
- Same cycle: mtc0_we to addr 14 with data DEAD_BEEF, and exc_req with new_epc=100 -> EPC=0000_0100.
- mtc0 Compare=5 with COUNT_DIV=1 and Count=0 -> timer_int=1 once Count reaches 5. A subsequent mtc0 Compare=20 -> timer_int=0.
- mtc0 Cause=FFFF_FFFF -> Cause reads 0080_0300 (bits 23 and 9:8 only).
- Second exc_req during FLUSH -> ignored; exactly one redirect_valid pulse. Pulling rst_n low in FLUSH -> flush=0 immediately and no redirect.

Source files
------------

// File: rtl/cp0_defs_pkg.sv
// CP0 register numbers, Status/Cause bit positions, reset defaults and the
// exception-sequencer state type shared by the CP0 exception controller files.
package cp0_defs;

  // CP0 register numbers reachable through MTC0/MFC0
  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;

  // Status bit positions
  localparam int unsigned STATUS_IE  = 0;
  localparam int unsigned STATUS_EXL = 1;
  localparam int unsigned STATUS_ERL = 2;
  localparam int unsigned STATUS_BEV = 22;

  // Cause bit positions
  localparam int unsigned CAUSE_EXC_LO = 2;
  localparam int unsigned CAUSE_EXC_HI = 6;
  localparam int unsigned CAUSE_IP_LO  = 8;
  localparam int unsigned CAUSE_HIP_LO = 10;
  localparam int unsigned CAUSE_IP_HI  = 15;
  localparam int unsigned CAUSE_TI     = 15;
  localparam int unsigned CAUSE_IV     = 23;
  localparam int unsigned CAUSE_BD     = 31;

  // Cause bits software may write: IV and the two software interrupt bits
  localparam logic [31:0] CAUSE_SW_MASK = 32'h0080_0300;

  // Status after reset: BEV=1, ERL=1, IE=0
  localparam logic [31:0] STATUS_RST_DEFAULT = 32'h0040_0004;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } exc_state_t;

  // Merge an MTC0 Cause write: only the software-writable bits change
  function automatic logic [31:0] cause_sw_merge(input logic [31:0] cur,
                                                 input logic [31:0] wdata);
    return (cur & ~CAUSE_SW_MASK) | (wdata & CAUSE_SW_MASK);
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: divided Count increment, Compare register and the
// sticky timer-pending flag that appears as Cause[15].
module cp0_timer #(
  parameter int unsigned COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic        set_pending,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        pending
);

  localparam logic [31:0] DIV_LAST = 32'(COUNT_DIV - 1);

  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic [31:0] div_q;
  logic        pending_q;
  logic        div_tick;
  logic [31:0] count_next;
  logic        hit;

  // Next Count value and compare match against the (unwritten) Compare
  always_comb begin
    div_tick   = (div_q == DIV_LAST);
    count_next = count_q;
    if (count_we)
      count_next = wdata;
    else if (div_tick)
      count_next = count_q + 32'd1;
    hit = !compare_we && (count_next == compare_q);
  end

  // Divider, Count and Compare registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= '0;
      count_q   <= '0;
      compare_q <= '1;
    end else begin
      if (count_we || div_tick)
        div_q <= '0;
      else
        div_q <= div_q + 32'd1;
      count_q <= count_next;
      if (compare_we)
        compare_q <= wdata;
    end
  end

  // Sticky pending flag: cleared only by a Compare write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pending_q <= 1'b0;
    else if (compare_we)
      pending_q <= 1'b0;
    else if (hit || set_pending)
      pending_q <= 1'b1;
  end

  assign count   = count_q;
  assign compare = compare_q;
  assign pending = pending_q;

endmodule

// File: rtl/cp0_exc_controller.sv
// CP0 register file (Count, Compare, Status, Cause, EPC) plus the sequencer
// that turns an exception/ERET commit into flush and PC redirect strobes.
module cp0_exc_controller
  import cp0_defs::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned COUNT_DIV    = 2,
  parameter logic [31:0] STATUS_RST   = STATUS_RST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exc_req,
  input  logic [31:0] exc_addr,
  input  logic        new_exl,
  input  logic [4:0]  new_exccode,
  input  logic        new_bd,
  input  logic [5:0]  new_hip,
  input  logic [31:0] new_epc,
  input  logic        mtc0_we,
  input  logic [4:0]  mtc0_addr,
  input  logic [31:0] mtc0_data,
  input  logic [4:0]  mfc0_addr,
  output logic [31:0] mfc0_data,
  output logic [31:0] status_out,
  output logic [31:0] cause_out,
  output logic [31:0] epc_out,
  output logic        timer_int,
  output logic        flush,
  output logic        stall,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  exc_state_t  state_q;
  logic [2:0]  flush_cnt_q;
  logic [31:0] status_q;
  logic [31:0] cause_q;
  logic [31:0] epc_q;
  logic [31:0] count_val;
  logic [31:0] compare_val;
  logic        timer_pending;
  logic        commit;
  logic        mtc0_ok;
  logic [31:0] cause_view;

  // Exceptions win over MTC0; neither is accepted outside IDLE
  always_comb begin
    commit  = (state_q == ST_IDLE) && exc_req;
    mtc0_ok = (state_q == ST_IDLE) && !exc_req && mtc0_we;
  end

  // cause_q[15] is never written; the live timer bit comes from the timer
  assign cause_view = cause_q | (32'(timer_pending) << CAUSE_TI);

  cp0_timer #(
    .COUNT_DIV(COUNT_DIV)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .count_we   (mtc0_ok && (mtc0_addr == REG_COUNT)),
    .compare_we (mtc0_ok && (mtc0_addr == REG_COMPARE)),
    .set_pending(commit && new_hip[5]),
    .wdata      (mtc0_data),
    .count      (count_val),
    .compare    (compare_val),
    .pending    (timer_pending)
  );

  // Status/Cause/EPC updates from exception commits or masked MTC0 writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q <= STATUS_RST;
      cause_q  <= '0;
      epc_q    <= '0;
    end else if (commit) begin
      status_q[STATUS_EXL]                <= new_exl;
      cause_q[CAUSE_BD]                   <= new_bd;
      cause_q[CAUSE_EXC_HI:CAUSE_EXC_LO]  <= new_exccode;
      cause_q[CAUSE_IP_HI-1:CAUSE_HIP_LO] <= new_hip[4:0];
      epc_q                               <= new_epc;
    end else if (mtc0_ok) begin
      case (mtc0_addr)
        REG_STATUS: status_q <= mtc0_data;
        REG_CAUSE:  cause_q  <= cause_sw_merge(cause_q, mtc0_data);
        REG_EPC:    epc_q    <= mtc0_data;
        default:    ;
      endcase
    end
  end

  // Sequencer: hold flush for FLUSH_CYCLES, then one redirect strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      flush_cnt_q    <= '0;
      flush          <= 1'b0;
      stall          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (exc_req) begin
            state_q     <= ST_FLUSH;
            flush_cnt_q <= 3'(FLUSH_CYCLES - 1);
            redirect_pc <= exc_addr;
            flush       <= 1'b1;
            stall       <= 1'b1;
          end
        end
        ST_FLUSH: begin
          if (flush_cnt_q == '0) begin
            state_q        <= ST_REDIRECT;
            flush          <= 1'b0;
            redirect_valid <= 1'b1;
          end else begin
            flush_cnt_q <= flush_cnt_q - 3'd1;
          end
        end
        ST_REDIRECT: begin
          state_q        <= ST_IDLE;
          redirect_valid <= 1'b0;
          stall          <= 1'b0;
        end
        default: begin
          state_q        <= ST_IDLE;
          flush          <= 1'b0;
          stall          <= 1'b0;
          redirect_valid <= 1'b0;
        end
      endcase
    end
  end

  // Combinational MFC0 read; same-cycle writes are not yet visible
  always_comb begin
    mfc0_data = '0;
    case (mfc0_addr)
      REG_COUNT:   mfc0_data = count_val;
      REG_COMPARE: mfc0_data = compare_val;
      REG_STATUS:  mfc0_data = status_q;
      REG_CAUSE:   mfc0_data = cause_view;
      REG_EPC:     mfc0_data = epc_q;
      default:     mfc0_data = '0;
    endcase
  end

  assign status_out = status_q;
  assign cause_out  = cause_view;
  assign epc_out    = epc_q;
  assign timer_int  = timer_pending;

endmodule

// File: tb/tb_cp0_exc_controller.sv
// Directed bench for cp0_exc_controller (FLUSH_CYCLES=1, COUNT_DIV=1).
module tb_cp0_exc_controller;

  logic        clk;
  logic        rst_n;
  logic        exc_req;
  logic [31:0] exc_addr;
  logic        new_exl;
  logic [4:0]  new_exccode;
  logic        new_bd;
  logic [5:0]  new_hip;
  logic [31:0] new_epc;
  logic        mtc0_we;
  logic [4:0]  mtc0_addr;
  logic [31:0] mtc0_data;
  logic [4:0]  mfc0_addr;
  logic [31:0] mfc0_data;
  logic [31:0] status_out;
  logic [31:0] cause_out;
  logic [31:0] epc_out;
  logic        timer_int;
  logic        flush;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int errors = 0;
  int checks = 0;

  cp0_exc_controller #(
    .FLUSH_CYCLES(1),
    .COUNT_DIV   (1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .exc_req       (exc_req),
    .exc_addr      (exc_addr),
    .new_exl       (new_exl),
    .new_exccode   (new_exccode),
    .new_bd        (new_bd),
    .new_hip       (new_hip),
    .new_epc       (new_epc),
    .mtc0_we       (mtc0_we),
    .mtc0_addr     (mtc0_addr),
    .mtc0_data     (mtc0_data),
    .mfc0_addr     (mfc0_addr),
    .mfc0_data     (mfc0_data),
    .status_out    (status_out),
    .cause_out     (cause_out),
    .epc_out       (epc_out),
    .timer_int     (timer_int),
    .flush         (flush),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    exc_req     = 1'b0;
    exc_addr    = '0;
    new_exl     = 1'b0;
    new_exccode = '0;
    new_bd      = 1'b0;
    new_hip     = '0;
    new_epc     = '0;
    mtc0_we     = 1'b0;
    mtc0_addr   = '0;
    mtc0_data   = '0;
    mfc0_addr   = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    clear_inputs();
    #1 rst_n = 1'b0;
    tick();
    tick();
    checks++; if (status_out !== 32'h0040_0004) begin errors++; $display("FAIL reset_status got=%h exp=%h", status_out, 32'h0040_0004); end
    checks++; if (cause_out !== 32'h0) begin errors++; $display("FAIL reset_cause got=%h exp=0", cause_out); end
    checks++; if (epc_out !== 32'h0) begin errors++; $display("FAIL reset_epc got=%h exp=0", epc_out); end
    checks++; if ({flush, stall, redirect_valid, timer_int} !== 4'b0000) begin errors++; $display("FAIL reset_ctrl got=%b exp=0000", {flush, stall, redirect_valid, timer_int}); end
    checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_rpc got=%h exp=0", redirect_pc); end
    mfc0_addr = 5'd11; #1;
    checks++; if (mfc0_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_compare got=%h exp=ffffffff", mfc0_data); end
    mfc0_addr = 5'd9; #1;
    checks++; if (mfc0_data !== 32'h0) begin errors++; $display("FAIL reset_count got=%h exp=0", mfc0_data); end
    #2 rst_n = 1'b1;
    mfc0_addr = 5'd12; #1;
    checks++; if (mfc0_data !== 32'h0040_0004) begin errors++; $display("FAIL reset_mfc0_status got=%h exp=00400004", mfc0_data); end
    tick();
  endtask

  task automatic test_exception();
    exc_req = 1'b1; exc_addr = 32'h8000_0180; new_epc = 32'h0000_1004;
    new_exccode = 5'h0C; new_exl = 1'b1; new_bd = 1'b1; new_hip = 6'b000101;
    tick();
    clear_inputs();
    checks++; if ({flush, stall, redirect_valid} !== 3'b110) begin errors++; $display("FAIL exc_flush got=%b exp=110", {flush, stall, redirect_valid}); end
    checks++; if (epc_out !== 32'h0000_1004) begin errors++; $display("FAIL exc_epc got=%h exp=00001004", epc_out); end
    checks++; if (cause_out !== 32'h8000_1430) begin errors++; $display("FAIL exc_cause got=%h exp=80001430", cause_out); end
    checks++; if (status_out !== 32'h0040_0006) begin errors++; $display("FAIL exc_status got=%h exp=00400006", status_out); end
    tick();
    checks++; if ({flush, stall, redirect_valid} !== 3'b011) begin errors++; $display("FAIL exc_redirect got=%b exp=011", {flush, stall, redirect_valid}); end
    checks++; if (redirect_pc !== 32'h8000_0180) begin errors++; $display("FAIL exc_rpc got=%h exp=80000180", redirect_pc); end
    tick();
    checks++; if ({flush, stall, redirect_valid} !== 3'b000) begin errors++; $display("FAIL exc_done got=%b exp=000", {flush, stall, redirect_valid}); end
  endtask

  task automatic test_collision();
    mtc0_we = 1'b1; mtc0_addr = 5'd14; mtc0_data = 32'hDEAD_BEEF;
    exc_req = 1'b1; exc_addr = 32'h8000_0200; new_epc = 32'h0000_0100;
    tick();
    clear_inputs();
    checks++; if (epc_out !== 32'h0000_0100) begin errors++; $display("FAIL collide_epc got=%h exp=00000100", epc_out); end
    checks++; if (cause_out !== 32'h0) begin errors++; $display("FAIL collide_cause got=%h exp=0", cause_out); end
    tick();
    tick();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL collide_idle got=%b exp=0", stall); end
  endtask

  task automatic test_mtc0_masks();
    mtc0_we = 1'b1; mtc0_addr = 5'd13; mtc0_data = 32'hFFFF_FFFF;
    tick();
    mtc0_addr = 5'd12; mtc0_data = 32'h1234_5678;
    tick();
    mtc0_addr = 5'd14; mtc0_data = 32'hCAFE_F00D;
    tick();
    mtc0_addr = 5'd5; mtc0_data = 32'hFFFF_FFFF;
    tick();
    mtc0_we = 1'b0;
    mfc0_addr = 5'd13; #1;
    checks++; if (mfc0_data !== 32'h0080_0300) begin errors++; $display("FAIL mtc0_cause got=%h exp=00800300", mfc0_data); end
    mfc0_addr = 5'd12; #1;
    checks++; if (mfc0_data !== 32'h1234_5678) begin errors++; $display("FAIL mtc0_status got=%h exp=12345678", mfc0_data); end
    mfc0_addr = 5'd5; #1;
    checks++; if (mfc0_data !== 32'h0) begin errors++; $display("FAIL mfc0_unmapped got=%h exp=0", mfc0_data); end
    mfc0_addr = 5'd14;
    mtc0_we = 1'b1; mtc0_addr = 5'd14; mtc0_data = 32'h1111_1111; #1;
    checks++; if (mfc0_data !== 32'hCAFE_F00D) begin errors++; $display("FAIL mfc0_old got=%h exp=cafef00d", mfc0_data); end
    tick();
    mtc0_we = 1'b0;
    checks++; if (mfc0_data !== 32'h1111_1111) begin errors++; $display("FAIL mfc0_new got=%h exp=11111111", mfc0_data); end
    clear_inputs();
  endtask

  task automatic test_timer();
    mtc0_we = 1'b1; mtc0_addr = 5'd11; mtc0_data = 32'd5;
    tick();
    mtc0_addr = 5'd9; mtc0_data = 32'd0;
    tick();
    mtc0_we = 1'b0;
    mfc0_addr = 5'd9; #1;
    checks++; if (mfc0_data !== 32'd0) begin errors++; $display("FAIL timer_count0 got=%h exp=0", mfc0_data); end
    for (int i = 0; i < 4; i++) tick();
    checks++; if ({mfc0_data, timer_int} !== {32'd4, 1'b0}) begin errors++; $display("FAIL timer_before got=%h/%b exp=4/0", mfc0_data, timer_int); end
    tick();
    checks++; if ({mfc0_data, timer_int} !== {32'd5, 1'b1}) begin errors++; $display("FAIL timer_hit got=%h/%b exp=5/1", mfc0_data, timer_int); end
    // exception with new_hip[5]=0 must not lose the pending timer bit
    exc_req = 1'b1; exc_addr = 32'h8000_0180; new_hip = 6'b0;
    tick();
    clear_inputs();
    checks++; if (cause_out[15] !== 1'b1 || timer_int !== 1'b1) begin errors++; $display("FAIL timer_keep got=%b/%b exp=1/1", cause_out[15], timer_int); end
    tick();
    tick();
    mtc0_we = 1'b1; mtc0_addr = 5'd11; mtc0_data = 32'd20;
    tick();
    mtc0_we = 1'b0; mfc0_addr = 5'd11; #1;
    checks++; if ({mfc0_data, timer_int} !== {32'd20, 1'b0}) begin errors++; $display("FAIL timer_clear got=%h/%b exp=14/0", mfc0_data, timer_int); end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    exc_req = 1'b1; exc_addr = 32'hBFC0_0380; new_epc = 32'h0000_0200;
    tick();
    pulses += int'(redirect_valid);
    exc_addr = 32'h1234_5678; new_epc = 32'h0000_0999;
    mtc0_we = 1'b1; mtc0_addr = 5'd14; mtc0_data = 32'h0000_5555;
    tick();
    pulses += int'(redirect_valid);
    checks++; if (redirect_pc !== 32'hBFC0_0380) begin errors++; $display("FAIL b2b_rpc got=%h exp=bfc00380", redirect_pc); end
    tick();
    pulses += int'(redirect_valid);
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      tick();
      pulses += int'(redirect_valid);
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL b2b_pulses got=%0d exp=1", pulses); end
    checks++; if (epc_out !== 32'h0000_0200) begin errors++; $display("FAIL b2b_epc got=%h exp=00000200", epc_out); end
  endtask

  task automatic test_reset_abort();
    int pulses = 0;
    exc_req = 1'b1; exc_addr = 32'h8000_0080;
    tick();
    clear_inputs();
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL abort_pre got=%b exp=1", flush); end
    rst_n = 1'b0; #1;
    checks++; if ({flush, stall, redirect_valid} !== 3'b000) begin errors++; $display("FAIL abort_ctrl got=%b exp=000", {flush, stall, redirect_valid}); end
    checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL abort_rpc got=%h exp=0", redirect_pc); end
    checks++; if (status_out !== 32'h0040_0004) begin errors++; $display("FAIL abort_status got=%h exp=00400004", status_out); end
    tick();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      pulses += int'(redirect_valid);
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_pulses got=%0d exp=0", pulses); end
  endtask

  initial begin
    test_reset();
    test_exception();
    test_collision();
    test_mtc0_masks();
    test_timer();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
